// File: rtl/hw_sw_msg_arbiter.sv
// Round-robin arbiter that serialises N hardware event messages onto the
// single CPU mailbox link, running the four-phase handshake with a SEND watchdog.
module hw_sw_msg_arbiter #(
  parameter int N       = 4,
  parameter int DW      = 16,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 50000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    done,
  output logic [N-1:0]    abort,
  output logic            busy,
  input  logic [1:0]      to_hw_sig,
  output logic [1:0]      to_sw_sig,
  output logic [DW-1:0]   to_sw_data,
  output logic [IDW-1:0]  to_sw_src
);

  localparam int             TW   = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT - 1);
  localparam logic [N-1:0]   ONE  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [IDW-1:0]  r_rr_ptr;
  logic [DW-1:0]   r_data;
  logic [IDW-1:0]  r_src;

  state_t          w_state_nxt;
  logic [TW-1:0]   w_timer_nxt;
  logic [IDW-1:0]  w_rr_nxt;
  logic            w_load;
  logic            w_gnt_found;
  logic [IDW-1:0]  w_gnt_idx;
  logic [DW-1:0]   w_gnt_data;
  logic [IDW-1:0]  w_src_succ;
  logic            w_ack;

  // First pending request at or after the round-robin pointer, with wrap.
  always_comb begin
    int j;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    j           = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(r_rr_ptr) + k) % N;
      if (!w_gnt_found && req[j]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = IDW'(j);
      end
    end
  end

  assign w_gnt_data = req_data[w_gnt_idx*DW +: DW];
  assign w_src_succ = (r_src == IDW'(N - 1)) ? '0 : r_src + IDW'(1);
  assign w_ack      = (to_hw_sig == 2'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_rr_nxt    = r_rr_ptr;
    w_load      = 1'b0;
    done        = '0;
    abort       = '0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_found) begin
          w_load      = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        // An ack arriving on the watchdog's last cycle still counts as delivered.
        if (w_ack) begin
          done        = ONE << r_src;
          w_rr_nxt    = w_src_succ;
          w_state_nxt = S_RELEASE;
        end else if (r_timer == TMAX) begin
          abort       = ONE << r_src;
          w_rr_nxt    = w_src_succ;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_RELEASE: begin
        if (to_hw_sig == 2'd0) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_rr_ptr <= '0;
      r_data   <= '0;
      r_src    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_rr_ptr <= w_rr_nxt;
      if (w_load) begin
        r_data <= w_gnt_data;
        r_src  <= w_gnt_idx;
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign to_sw_sig  = (r_state == S_SEND) ? 2'd2 : 2'd0;
  assign to_sw_data = r_data;
  assign to_sw_src  = r_src;

endmodule

// File: tb/tb_hw_sw_msg_arbiter.sv
// Bench for hw_sw_msg_arbiter: directed scenarios plus random transactions,
// each scored against a transaction-level model of grant order and handshake timing.
module tb_hw_sw_msg_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int IDW = 2;
  localparam int TO  = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [1:0]      to_hw_sig = 2'd0;
  logic [N-1:0]    done;
  logic [N-1:0]    abort;
  logic            busy;
  logic [1:0]      to_sw_sig;
  logic [DW-1:0]   to_sw_data;
  logic [IDW-1:0]  to_sw_src;

  int n_checks = 0;
  int n_errors = 0;
  int m_ptr    = 0;
  int g_src    = -1;

  always #5 clk = ~clk;

  hw_sw_msg_arbiter #(.N(N), .DW(DW), .IDW(IDW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_data   (req_data),
    .done       (done),
    .abort      (abort),
    .busy       (busy),
    .to_hw_sig  (to_hw_sig),
    .to_sw_sig  (to_sw_sig),
    .to_sw_data (to_sw_data),
    .to_sw_src  (to_sw_src)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (reset_n) chk("excl", 32'($countones(done | abort) <= 1), 32'd1);
  end

  // Starts in an IDLE cycle (just after a negedge); ends in the next IDLE cycle.
  // ack_at: SEND cycle (1-based) in which the CPU acks; > TO means never.
  task automatic xfer(input logic [N-1:0] add, input int ack_at, input int rel_hold, input int fixed);
    int w;
    logic [DW-1:0] exp_d;
    req = req | add;
    req_data = {$urandom, $urandom};
    w = pick(req, m_ptr);
    if (w < 0) begin
      chk("no_req_idle", 32'(busy), 32'd0);
      return;
    end
    if (fixed >= 0) req_data[w*DW +: DW] = fixed[DW-1:0];
    exp_d = req_data[w*DW +: DW];
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      if (c == 1) begin
        g_src = int'(to_sw_src);
        chk("send_sig", 32'(to_sw_sig), 32'd2);
        chk("send_src", 32'(to_sw_src), 32'(w));
        chk("send_data", 32'(to_sw_data), 32'(exp_d));
      end
      req_data  = {$urandom, $urandom};
      to_hw_sig = (c == ack_at) ? 2'd1 : 2'd0;
      #1;
      chk("data_stable", 32'(to_sw_data), 32'(exp_d));
      if (c == ack_at) begin
        chk("done", 32'(done), 32'(1 << w));
        chk("no_abort", 32'(abort), 32'd0);
        break;
      end else if (c == TO) begin
        chk("abort", 32'(abort), 32'(1 << w));
        chk("no_done", 32'(done), 32'd0);
      end else begin
        chk("send_quiet", 32'({done, abort}), 32'd0);
        chk("send_hold", 32'(to_sw_sig), 32'd2);
      end
    end
    m_ptr = (w + 1) % N;
    if (ack_at <= TO) begin
      for (int r = 0; r <= rel_hold; r++) begin
        @(negedge clk);
        if (r == 0) req[w] = 1'b0;
        to_hw_sig = (r < rel_hold) ? 2'd1 : 2'd0;
        #1;
        chk("rel_sig", 32'(to_sw_sig), 32'd0);
        chk("rel_busy", 32'(busy), 32'd1);
        chk("rel_quiet", 32'({done, abort}), 32'd0);
        chk("rel_src", 32'(to_sw_src), 32'(w));
        chk("rel_data", 32'(to_sw_data), 32'(exp_d));
      end
    end
    @(negedge clk);
    req[w] = 1'b0;
    to_hw_sig = 2'd0;
    #1;
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_sig", 32'(to_sw_sig), 32'd0);
    chk("end_quiet", 32'({done, abort}), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    to_hw_sig = 2'd0;
    #2;
    reset_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int rr_exp [5];
    int add, ack, rel;
    rr_exp = '{0, 1, 2, 3, 0};

    @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sig", 32'(to_sw_sig), 32'd0);
    chk("rst_data", 32'(to_sw_data), 32'd0);
    chk("rst_src", 32'(to_sw_src), 32'd0);
    chk("rst_pulses", 32'({done, abort}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    #1;

    // Single message with a fixed payload
    xfer(4'b0100, 5, 3, 'hBEEF);
    chk("single_src", 32'(g_src), 32'd2);
    chk("beef_hold", 32'(to_sw_data), 32'hBEEF);

    // Round robin with all requesters pending
    do_reset();
    for (int i = 0; i < 5; i++) begin
      xfer(4'b1111, int'($urandom_range(1, 3)), 0, -1);
      chk("rr_order", 32'(g_src), 32'(rr_exp[i]));
    end
    req = '0;
    @(negedge clk);
    #1;
    xfer(4'b1001, 2, 1, -1);
    chk("rr_1001_a", 32'(g_src), 32'd3);
    xfer(4'b0000, 1, 0, -1);
    chk("rr_1001_b", 32'(g_src), 32'd0);

    // Watchdog: requester 1 is never acked; pointer then moves past it
    xfer(4'b0010, TO + 5, 0, -1);
    chk("to_src", 32'(g_src), 32'd1);
    xfer(4'b0110, 1, 0, -1);
    chk("ptr_after_to", 32'(g_src), 32'd2);
    req = '0;

    // Ack on the last watchdog cycle
    xfer(4'b0001, TO, 1, -1);
    chk("coll_src", 32'(g_src), 32'd0);

    // Stray CPU ack while idle
    req = '0;
    to_hw_sig = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("stray_busy", 32'(busy), 32'd0);
      chk("stray_quiet", 32'({done, abort, to_sw_sig}), 32'd0);
    end
    xfer(4'b0001, 3, 0, -1);
    chk("stray_src", 32'(g_src), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 25; i++) begin
      add = int'($urandom_range(0, 15));
      if ((req | add[N-1:0]) == '0) add = 1;
      ack = int'($urandom_range(1, TO + 2));
      rel = int'($urandom_range(0, 3));
      xfer(add[N-1:0], ack, rel, -1);
    end

    // Reset asserted in the middle of SEND
    req = req | 4'b0001;
    req_data = {$urandom, $urandom};
    to_hw_sig = 2'd0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid_sig", 32'(to_sw_sig), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("arst_sig", 32'(to_sw_sig), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_pulses", 32'({done, abort}), 32'd0);
    chk("arst_data", 32'(to_sw_data), 32'd0);
    chk("arst_src", 32'(to_sw_src), 32'd0);
    @(negedge clk);
    req = 4'b0010;
    reset_n = 1'b1;
    m_ptr = 0;
    xfer(4'b0000, 2, 0, -1);
    chk("post_rst_src", 32'(g_src), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
